pipeline_hazard_ctrl: RTL



---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline control types: latch control encoding, hazard FSM states,
// register index type.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      PIPE_NORMAL = 2'b00,
      PIPE_STALL  = 2'b01,
      PIPE_FLUSH  = 2'b10
   } pipe_state_t;

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      DWAIT   = 2'b01,
      HALTING = 2'b10,
      HALTED  = 2'b11
   } hzd_fsm_t;

   localparam int unsigned REGBITS_W = 5;
   typedef logic [REGBITS_W-1:0] regbits_t;

   // True when any of the four latch controls requests a bubble.
   function automatic logic anyFlush(input pipe_state_t a, input pipe_state_t b,
                                     input pipe_state_t c, input pipe_state_t d);
      return (a == PIPE_FLUSH) || (b == PIPE_FLUSH) ||
             (c == PIPE_FLUSH) || (d == PIPE_FLUSH);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a DEC source.
// Register $0 is hardwired to zero and never creates a dependency.
module hazard_detect #(
   parameter int unsigned REG_W = 5
) (
   input  logic             dREN_ex,
   input  logic             RegWrite_ex,
   input  logic [REG_W-1:0] regWSEL_ex,
   input  logic [REG_W-1:0] rs_dec,
   input  logic [REG_W-1:0] rt_dec,
   input  logic             rt_used_dec,
   output logic             loaduse
);

   logic rsMatch;
   logic rtMatch;

   // Compare the EX destination against both DEC sources.
   always_comb begin
      rsMatch = (regWSEL_ex == rs_dec);
      rtMatch = rt_used_dec && (regWSEL_ex == rt_dec);
      loaduse = dREN_ex && RegWrite_ex && (regWSEL_ex != '0) && (rsMatch || rtMatch);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: drives the four pipeline latch controls and the
// PC enable, resolving dmem wait, control redirect, load-use and imem wait,
// and sequencing halt. Optional performance counters are built only when
// HAZARD_PERF_EN is defined; otherwise the counter outputs are tied to zero.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_mem,
   input  logic             dWEN_mem,
   input  logic             dREN_ex,
   input  logic             RegWrite_ex,
   input  logic [REG_W-1:0] regWSEL_ex,
   input  logic [REG_W-1:0] rs_dec,
   input  logic [REG_W-1:0] rt_dec,
   input  logic             rt_used_dec,
   input  logic             redirect_mem,
   input  logic             halt_mem,
   input  logic             halt_wb,
   output pipe_state_t      fd_state,
   output pipe_state_t      de_state,
   output pipe_state_t      em_state,
   output pipe_state_t      mw_state,
   output logic             pc_en,
   output logic             pc_redirect,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
);

   hzd_fsm_t state, stateNext;
   logic     pendRedir, pendRedirNext;
   logic     loaduse;
   logic     memWait;
   logic     redirect;

   hazard_detect #(.REG_W(REG_W)) uDetect (
      .dREN_ex     (dREN_ex),
      .RegWrite_ex (RegWrite_ex),
      .regWSEL_ex  (regWSEL_ex),
      .rs_dec      (rs_dec),
      .rt_dec      (rt_dec),
      .rt_used_dec (rt_used_dec),
      .loaduse     (loaduse)
   );

   // FSM state and pending-redirect flag registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= RUN;
         pendRedir <= 1'b0;
      end else begin
         state     <= stateNext;
         pendRedir <= pendRedirNext;
      end
   end

   // Next state and latch/PC controls, highest-priority hazard first.
   always_comb begin
      fd_state      = PIPE_NORMAL;
      de_state      = PIPE_NORMAL;
      em_state      = PIPE_NORMAL;
      mw_state      = PIPE_NORMAL;
      pc_en         = 1'b0;
      pc_redirect   = 1'b0;
      halted        = 1'b0;
      stateNext     = state;
      pendRedirNext = pendRedir;
      redirect      = redirect_mem || pendRedir;
      // Once in DWAIT the stall is held until dhit, even if the MEM request drops.
      memWait       = (state == DWAIT) ? !dhit : ((dREN_mem || dWEN_mem) && !dhit);

      if (RST) begin
         fd_state = PIPE_FLUSH;
         de_state = PIPE_FLUSH;
         em_state = PIPE_FLUSH;
         mw_state = PIPE_FLUSH;
      end else begin
         case (state)
            RUN, DWAIT: begin
               if (state == RUN) begin
                  if (halt_mem)     stateNext = HALTING;
                  else if (memWait) stateNext = DWAIT;
               end else if (dhit) begin
                  stateNext = RUN;
               end

               if (memWait) begin
                  fd_state = PIPE_STALL;
                  de_state = PIPE_STALL;
                  em_state = PIPE_STALL;
                  mw_state = PIPE_STALL;
               end else if (redirect) begin
                  fd_state = PIPE_FLUSH;
                  de_state = PIPE_FLUSH;
                  em_state = PIPE_FLUSH;
                  if (ihit) begin
                     pc_en         = 1'b1;
                     pc_redirect   = 1'b1;
                     pendRedirNext = 1'b0;
                  end else begin
                     pendRedirNext = 1'b1;
                  end
               end else if (loaduse) begin
                  fd_state = PIPE_STALL;
                  de_state = PIPE_FLUSH;
               end else if (!ihit) begin
                  fd_state = PIPE_FLUSH;
               end else begin
                  pc_en = 1'b1;
               end
            end
            HALTING: begin
               if (halt_wb) stateNext = HALTED;
               if (memWait) begin
                  fd_state = PIPE_STALL;
                  de_state = PIPE_STALL;
                  em_state = PIPE_STALL;
                  mw_state = PIPE_STALL;
               end else begin
                  fd_state = PIPE_FLUSH;
                  de_state = PIPE_FLUSH;
                  em_state = PIPE_FLUSH;
               end
            end
            HALTED: begin
               halted   = 1'b1;
               fd_state = PIPE_STALL;
               de_state = PIPE_STALL;
               em_state = PIPE_STALL;
               mw_state = PIPE_STALL;
            end
            default: begin
               stateNext = RUN;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   // Performance counters: stalled-PC cycles (outside HALTED) and bubble cycles.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (!pc_en && (state != HALTED)) stallCnt <= stallCnt + CNT_W'(1);
         if (anyFlush(fd_state, de_state, em_state, mw_state)) flushCnt <= flushCnt + CNT_W'(1);
      end
   end

   assign stall_cycles = stallCnt;
   assign flush_cycles = flushCnt;
`else
   assign stall_cycles = '0;
   assign flush_cycles = '0;
`endif

endmodule
